// File: rtl/inst_fetch_buffer.sv
// ---------------------------------------------------------------------------
// inst_fetch_buffer
//
// Instruction-fetch stage sitting directly behind the PC register. It turns
// the pc/ce pair into in-order requests to a variable-latency instruction
// memory (req/gnt/rvalid). Returned words are buffered with their PC in a
// small FIFO and presented to the IF/ID stage over valid/ready.
//
// Parameters:
//   FIFO_DEPTH       entries of {pc, inst}; power of two, >= 2
//   MAX_OUTSTANDING  granted-but-unanswered requests allowed, 1..FIFO_DEPTH
//
// Ports:
//   clk, rst         clock; synchronous active-high reset
//   pc_i, ce_i       fetch address / fetch enable from the PC stage
//   pc_stall_o       PC stage must hold pc_i this cycle
//   imem_req_o       memory request, imem_addr_o request address
//   imem_gnt_i       request accepted this cycle
//   imem_rvalid_i    response valid (in request order), imem_rdata_i data
//   flush_i          drop all buffered and in-flight fetches
//   id_valid_o       FIFO head valid, id_ready_i head accepted
//   id_pc_o          PC of head, id_inst_o instruction of head
//   id_exc_o         head fetch exception (misaligned PC)
//
// Optional feature, macro IF_MISALIGN_EXC_EN: requests with pc_i[1:0] != 0
// are issued word-aligned, and their FIFO entry carries id_exc_o = 1 with a
// zeroed instruction. Without the macro the address passes through and
// id_exc_o is tied to 0.
// ---------------------------------------------------------------------------
module inst_fetch_buffer #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_i,
  input  logic        ce_i,
  output logic        pc_stall_o,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        flush_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o,
  output logic        id_exc_o
);

  localparam int FAW = $clog2(FIFO_DEPTH);
  localparam int CW  = FAW + 1;
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int SW  = CW + 1;

  logic [CW-1:0]  count_q, count_d;
  logic [OW-1:0]  outstanding_q, outstanding_d;
  logic [OW-1:0]  discard_q, discard_d;
  logic [FAW-1:0] fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [PW-1:0]  pq_wr_q, pq_wr_d, pq_rd_q, pq_rd_d;

  logic [31:0] fifo_pc_q   [FIFO_DEPTH];
  logic [31:0] fifo_inst_q [FIFO_DEPTH];
  logic [31:0] pq_pc_q     [MAX_OUTSTANDING];

  logic        credit, grant, resp, push, pop;
  logic [31:0] push_inst;
  logic        head_exc;

  // Pending-queue depth need not be a power of two, so wrap explicitly.
  function automatic logic [PW-1:0] pq_next(input logic [PW-1:0] p);
    return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  // In-flight requests reserve a FIFO slot, so a response can always land.
  assign credit = ((SW'(count_q) + SW'(outstanding_q)) < SW'(FIFO_DEPTH)) &&
                  (outstanding_q < OW'(MAX_OUTSTANDING));

  assign imem_req_o = ce_i & ~flush_i & credit & ~rst;
  assign grant      = imem_req_o & imem_gnt_i;
  assign pc_stall_o = ce_i & ~grant;

  // A response with nothing outstanding (e.g. left over from before reset)
  // is spurious and ignored.
  assign resp = imem_rvalid_i & (outstanding_q != '0);
  assign push = resp & ~flush_i & (discard_q == '0);

  assign id_valid_o = (count_q != '0);
  assign pop        = id_valid_o & id_ready_i;

  always_comb begin
    count_d       = count_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_rd_d     = fifo_rd_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    pq_wr_d       = pq_wr_q;
    pq_rd_d       = pq_rd_q;

    unique case ({grant, resp})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase
    if (grant) pq_wr_d = pq_next(pq_wr_q);
    if (resp)  pq_rd_d = pq_next(pq_rd_q);

    if (flush_i) begin
      count_d   = '0;
      fifo_wr_d = '0;
      fifo_rd_d = '0;
      // Everything still in flight after this cycle belongs to the old stream.
      discard_d = outstanding_d;
    end else begin
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push) fifo_wr_d = fifo_wr_q + 1'b1;
      if (pop)  fifo_rd_d = fifo_rd_q + 1'b1;
      if (resp && (discard_q != '0)) discard_d = discard_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q       <= '0;
      outstanding_q <= '0;
      discard_q     <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      pq_wr_q       <= '0;
      pq_rd_q       <= '0;
    end else begin
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_rd_q     <= fifo_rd_d;
      pq_wr_q       <= pq_wr_d;
      pq_rd_q       <= pq_rd_d;
    end
  end

  // Storage arrays need no reset: occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (grant) pq_pc_q[pq_wr_q] <= pc_i;
    if (push) begin
      fifo_pc_q[fifo_wr_q]   <= pq_pc_q[pq_rd_q];
      fifo_inst_q[fifo_wr_q] <= push_inst;
    end
  end

`ifdef IF_MISALIGN_EXC_EN
  logic pq_mis_q   [MAX_OUTSTANDING];
  logic fifo_exc_q [FIFO_DEPTH];
  logic req_mis, pop_mis;

  assign req_mis     = (pc_i[1:0] != 2'b00);
  assign imem_addr_o = {pc_i[31:2], 2'b00};
  assign pop_mis     = pq_mis_q[pq_rd_q];
  assign push_inst   = pop_mis ? 32'h0 : imem_rdata_i;
  assign head_exc    = fifo_exc_q[fifo_rd_q];

  always_ff @(posedge clk) begin
    if (grant) pq_mis_q[pq_wr_q] <= req_mis;
    if (push)  fifo_exc_q[fifo_wr_q] <= pop_mis;
  end
`else
  assign imem_addr_o = pc_i;
  assign push_inst   = imem_rdata_i;
  assign head_exc    = 1'b0;
`endif

  assign id_pc_o   = id_valid_o ? fifo_pc_q[fifo_rd_q]   : 32'h0;
  assign id_inst_o = id_valid_o ? fifo_inst_q[fifo_rd_q] : 32'h0;
  assign id_exc_o  = id_valid_o & head_exc;

endmodule
